// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage between the PC stage and decode.
// Drives the PC operation code, issues single-outstanding req/ack memory reads,
// and buffers returned words with their PC in a DEPTH-entry FIFO for decode.
// Optional feature macro: FETCH_MISALIGN_EN (misaligned PC blocks fetch, sticky misalign_o).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   pc_i                       current PC from the PC stage
//   pc_op_o, pc_target_o       PC operation (00 clr, 01 hold, 10 +4, 11 load) and load target
//   redirect_i, redirect_pc_i  one-cycle branch/jump redirect and its target
//   mem_req_o, mem_addr_o      memory read request and address
//   mem_ack_i, mem_rdata_i     read completion and data
//   instr_valid_o, instr_ready_i, instr_o, instr_pc_o   decode handshake and head entry
//   misalign_o                 sticky misaligned-fetch flag
module fetch_queue #(
   parameter int ANCHO   = 32,
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ANCHO-1:0]   pc_i,
   output logic [1:0]         pc_op_o,
   output logic [ANCHO-1:0]   pc_target_o,
   input  logic               redirect_i,
   input  logic [ANCHO-1:0]   redirect_pc_i,
   output logic               mem_req_o,
   output logic [ANCHO-1:0]   mem_addr_o,
   input  logic               mem_ack_i,
   input  logic [INSTR_W-1:0] mem_rdata_i,
   output logic               instr_valid_o,
   input  logic               instr_ready_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ANCHO-1:0]   instr_pc_o,
   output logic               misalign_o
);
   localparam int PW = $clog2(DEPTH);
   typedef enum logic [1:0] {CLR, FETCH, FULL, DROP} state_t;
   state_t state, state_n;
   logic [INSTR_W-1:0] fifo_instr [DEPTH];
   logic [ANCHO-1:0]   fifo_pc [DEPTH];
   logic [PW-1:0]      wptr, rptr;
   logic [PW:0]        count, count_n;
   logic [ANCHO-1:0]   addr_q, pend_pc;
   logic               pend, redir, ack, push, pop, bad;
   // a redirect seen during CLR is replayed on the following cycle
   assign redir = (state != CLR) && (redirect_i || pend);
`ifdef FETCH_MISALIGN_EN
   logic mis_q;
   assign bad        = (state == FETCH) && (pc_i[1:0] != 2'b00);
   assign misalign_o = mis_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) mis_q <= 1'b0;
      else       mis_q <= redir ? 1'b0 : (mis_q | bad);
`else
   assign bad        = 1'b0;
   assign misalign_o = 1'b0;
`endif
   assign instr_valid_o = count != '0;
   assign instr_o       = fifo_instr[rptr];
   assign instr_pc_o    = fifo_pc[rptr];
   always_comb begin
      mem_req_o   = (state == DROP) || ((state == FETCH) && !bad);
      mem_addr_o  = (state == DROP) ? addr_q : pc_i;
      ack         = mem_ack_i && mem_req_o;
      push        = (state == FETCH) && ack && !redir;
      pop         = instr_valid_o && instr_ready_i;
      count_n     = count + (PW+1)'(push) - (PW+1)'(pop);
      pc_op_o     = (state == CLR) ? 2'b00 : redir ? 2'b11 : push ? 2'b10 : 2'b01;
      pc_target_o = redir ? (redirect_i ? redirect_pc_i : pend_pc) : '0;
      state_n     = state;
      case (state)
         CLR:     state_n = FETCH;
         // a redirect with the request still open must wait out its ack in DROP
         FETCH:   state_n = redir ? ((mem_req_o && !ack) ? DROP : FETCH)
                                  : (push && count_n == (PW+1)'(DEPTH)) ? FULL : FETCH;
         FULL:    state_n = (redir || pop) ? FETCH : FULL;
         DROP:    state_n = (redir || !ack) ? DROP : FETCH;
         default: state_n = CLR;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= CLR;
      else       state <= state_n;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         addr_q  <= '0;
         pend    <= 1'b0;
         pend_pc <= '0;
      end else begin
         pend <= (state == CLR) && redirect_i;
         if (state == CLR) pend_pc <= redirect_pc_i;
         if (state == FETCH) addr_q <= pc_i;
         if (redir) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count <= count_n;
         end
      end
   end
   always_ff @(posedge clk)
      if (push) begin
         fifo_instr[wptr] <= mem_rdata_i;
         fifo_pc[wptr]    <= pc_i;
      end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Drives the PC operation code (00 clear, 01 hold, 10 increment by 4, 11 load target) and takes the PC value back.
- Issues single-outstanding req/ack reads to instruction memory and buffers returned words with their PC in a small FIFO.
- Presents buffered instructions to decode through a valid/ready handshake.

Parameters:
- ANCHO, 32, PC / memory address width.
- INSTR_W, 32, instruction word width.
- DEPTH, 2, FIFO entries (power of two, >= 2).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_i  input  ANCHO  current PC value (registered output of the PC stage).
- pc_op_o  output  2  PC operation code to the PC stage.
- pc_target_o  output  ANCHO  load target for PC (valid when pc_op_o==11).
- redirect_i  input  1  branch/jump redirect strobe, one cycle.
- redirect_pc_i  input  ANCHO  redirect target address.
- mem_req_o  output  1  memory read request.
- mem_addr_o  output  ANCHO  memory read address.
- mem_ack_i  input  1  read complete; mem_rdata_i valid this cycle.
- mem_rdata_i  input  INSTR_W  read data.
- instr_valid_o  output  1  FIFO head valid.
- instr_ready_i  input  1  decode accepts head.
- instr_o  output  INSTR_W  head instruction.
- instr_pc_o  output  ANCHO  PC of head instruction.
- misalign_o  output  1  misaligned fetch flag (tied 0 unless the optional feature is enabled).

Behaviour:
- Reset (async assert, sync release) sets the following.
  - State CLR, FIFO empty, count 0.
  - mem_req_o=0, instr_valid_o=0, pc_op_o=00, pc_target_o=0, addr_q=0, misalign_o=0.
- FSM states: CLR, FETCH, FULL, DROP.
- CLR:
  - Drives pc_op_o=00 for exactly one cycle, then goes to FETCH.
- FETCH:
  - mem_req_o=1, mem_addr_o=pc_i, addr_q<=pc_i every cycle.
  - pc_op_o=01 while mem_ack_i=0.
  - On mem_ack_i, with no redirect:
    - Push {pc_i, mem_rdata_i}.
    - pc_op_o=10.
    - Go to FULL if post-push count==DEPTH, else stay in FETCH.
- FULL:
  - mem_req_o=0, pc_op_o=01.
  - Returns to FETCH on the cycle after a pop makes count<DEPTH.
- DROP:
  - mem_req_o=1, mem_addr_o=addr_q (address held stable), pc_op_o=01.
  - On mem_ack_i the data is discarded (no push) and the state goes to FETCH.
- Request rule:
  - mem_req_o, once high, stays high with a stable address until mem_ack_i.
  - A request is only started when count<DEPTH, so an ack always has room.
- Redirect (highest priority, any state except CLR; in CLR it is honoured on the next cycle):
  - pc_op_o=11, pc_target_o=redirect_pc_i.
  - FIFO flushed: count 0, instr_valid_o=0 next cycle.
  - FETCH with no ack in the same cycle: go to DROP.
  - FETCH with ack in the same cycle: data dropped, go to FETCH.
  - FULL: go to FETCH.
  - DROP: stay in DROP.
- FIFO:
  - instr_valid_o = count!=0; head shown combinationally from the read pointer.
  - Pop on instr_valid_o && instr_ready_i.
  - Simultaneous push and pop keeps count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency:
  - Instruction visible on instr_o the cycle after mem_ack_i.
  - With zero-wait memory and ready held high, throughput is 1 instruction per 2 cycles (PC updates one cycle after pc_op_o=10).
- PC arithmetic is performed by the PC stage; this block never adds.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Enabled, in FETCH:
  - If pc_i[1:0]!=0, no request is issued: mem_req_o=0, pc_op_o=01.
  - misalign_o is set and is sticky until the next redirect or reset.
  - A redirect clears misalign_o and resumes normal fetching.
- Disabled:
  - misalign_o is tied 0.
  - Alignment is not checked; the address is passed through unchanged.

Test Plan:
- Reset release, memory acks each request in 1 cycle, pc_i follows pc_op_o from 0, ready=1 -> pc_op_o 00 once, then alternating 01/10; instr_pc_o sequence 0x0, 0x4, 0x8 with matching rdata.
- ready=0, DEPTH=2 -> two pushes (PC 0x0, 0x4), then FULL with mem_req_o=0 and pc_op_o=01 held; one pop -> FETCH resumes at 0x8.
- Redirect to 0x100 while a request to 0x8 is pending, ack 3 cycles later -> pc_op_o=11, pc_target_o=0x100; mem_addr_o stays 0x8 until ack; data not pushed; next request addresses 0x100.
- Redirect and ack in the same cycle -> FIFO empty next cycle, acked word absent, next fetch at the target.
- Assert reset mid-request with 2 entries queued -> all outputs return to reset values immediately; after release, pc_op_o=00 is seen again.
- FETCH_MISALIGN_EN defined, redirect to 0x102 -> misalign_o=1, no mem_req_o; redirect to 0x200 -> misalign_o=0, fetch at 0x200.
